// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared types, constants and CRC-32 byte step for the Ethernet TX framer
package eth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SFD,
        DATA,
        PAD,
        FCS,
        IFG
    } tx_state_t;

    localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
    localparam logic [7:0]  ETH_SFD      = 8'hD5;
    localparam logic [31:0] CRC32_POLY_R = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;

    // One byte through the reflected CRC-32, LSB of the byte first.
    function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_R) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// rtl/eth_crc32_d8.sv - byte-wide CRC-32 accumulator with init and enable
module eth_crc32_d8
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    always_ff @(posedge clk) begin
        if (rst || init) begin
            crc <= CRC32_INIT;
        end else if (en) begin
            crc <= crc32_step(crc, data);
        end
    end

endmodule

// File: rtl/eth_frame_tx.sv
// rtl/eth_frame_tx.sv - GMII Ethernet TX framer; define ETH_TX_PAD_EN to zero-pad short frames
module eth_frame_tx
    import eth_pkg::*;
#(
    parameter int PREAMBLE_LEN  = 7,
    parameter int MIN_FRAME_LEN = 60,
    parameter int IFG_CYCLES    = 12
) (
    input  logic        gmii_tx_clk,
    input  logic        rst,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic [7:0]  gmii_txd,
    output logic        tx_busy,
    output logic        frame_done,
    output logic        underrun,
    output logic [15:0] frame_cnt
);

`ifdef ETH_TX_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    // IDLE always contributes one gap cycle, so IFG itself lasts IFG_CYCLES-1.
    localparam tx_state_t GAP_STATE = (IFG_CYCLES > 1) ? IFG : IDLE;

    tx_state_t   state;
    tx_state_t   state_next;
    logic [15:0] phase_cnt;
    logic [10:0] byte_cnt;
    logic [10:0] byte_cnt_inc;
    logic [31:0] crc;

    logic        crc_init;
    logic        crc_en;
    logic [7:0]  crc_data;
    logic        out_en;
    logic        out_er;
    logic [7:0]  out_d;
    logic        done_next;
    logic        underrun_next;
    logic        accept;

    assign s_ready      = (state == DATA);
    assign tx_busy      = (state != IDLE);
    assign accept       = s_valid && s_ready;
    assign byte_cnt_inc = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;

    eth_crc32_d8 u_crc (
        .clk  (gmii_tx_clk),
        .rst  (rst),
        .init (crc_init),
        .en   (crc_en),
        .data (crc_data),
        .crc  (crc)
    );

    always_comb begin
        state_next    = state;
        crc_init      = 1'b0;
        crc_en        = 1'b0;
        crc_data      = s_data;
        out_en        = 1'b0;
        out_er        = 1'b0;
        out_d         = 8'h00;
        done_next     = 1'b0;
        underrun_next = 1'b0;
        case (state)
            IDLE: begin
                crc_init = 1'b1;
                if (s_valid) state_next = PRE;
            end
            PRE: begin
                out_en = 1'b1;
                out_d  = ETH_PREAMBLE;
                if (phase_cnt == 16'(PREAMBLE_LEN - 1)) state_next = SFD;
            end
            SFD: begin
                out_en     = 1'b1;
                out_d      = ETH_SFD;
                state_next = DATA;
            end
            DATA: begin
                out_en = 1'b1;
                if (accept) begin
                    out_d  = s_data;
                    crc_en = 1'b1;
                    if (s_last) begin
                        if (PAD_EN && (byte_cnt_inc < 11'(MIN_FRAME_LEN))) state_next = PAD;
                        else state_next = FCS;
                    end
                end else begin
                    // Source starved mid-frame: poison the frame and skip the FCS.
                    out_er        = 1'b1;
                    underrun_next = 1'b1;
                    state_next    = GAP_STATE;
                end
            end
`ifdef ETH_TX_PAD_EN
            PAD: begin
                out_en   = 1'b1;
                crc_en   = 1'b1;
                crc_data = 8'h00;
                if (byte_cnt_inc >= 11'(MIN_FRAME_LEN)) state_next = FCS;
            end
`endif
            FCS: begin
                out_en = 1'b1;
                out_d  = ~crc[{phase_cnt[1:0], 3'b000} +: 8];
                if (phase_cnt[1:0] == 2'd3) begin
                    done_next  = 1'b1;
                    state_next = GAP_STATE;
                end
            end
            IFG: begin
                if (phase_cnt == 16'(IFG_CYCLES - 2)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge gmii_tx_clk) begin
        if (rst) begin
            state      <= IDLE;
            phase_cnt  <= 16'd0;
            byte_cnt   <= 11'd0;
            gmii_tx_en <= 1'b0;
            gmii_tx_er <= 1'b0;
            gmii_txd   <= 8'h00;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            frame_cnt  <= 16'd0;
        end else begin
            state      <= state_next;
            phase_cnt  <= (state_next != state) ? 16'd0 : phase_cnt + 16'd1;
            if (state == IDLE) begin
                byte_cnt <= 11'd0;
            end else if (accept || (state == PAD)) begin
                byte_cnt <= byte_cnt_inc;
            end
            gmii_tx_en <= out_en;
            gmii_tx_er <= out_er;
            gmii_txd   <= out_d;
            frame_done <= done_next;
            underrun   <= underrun_next;
            if (done_next) frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_eth_frame_tx.sv
// tb/tb_eth_frame_tx.sv - self-checking bench for eth_frame_tx
module tb_eth_frame_tx;

`ifdef ETH_TX_PAD_EN
    localparam bit PAD_ON = 1'b1;
`else
    localparam bit PAD_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic        gmii_tx_en;
    logic        gmii_tx_er;
    logic [7:0]  gmii_txd;
    logic        tx_busy;
    logic        frame_done;
    logic        underrun;
    logic [15:0] frame_cnt;

    eth_frame_tx dut (
        .gmii_tx_clk (clk),
        .rst         (rst),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .gmii_tx_en  (gmii_tx_en),
        .gmii_tx_er  (gmii_tx_er),
        .gmii_txd    (gmii_txd),
        .tx_busy     (tx_busy),
        .frame_done  (frame_done),
        .underrun    (underrun),
        .frame_cnt   (frame_cnt)
    );

    always #4 clk = ~clk;

    typedef struct {
        int          len;
        logic [7:0]  seed;
        logic [7:0]  step;
        int          cyc_nopad;
        int          cyc_pad;
        logic [31:0] fcs_nopad;
    } vec_t;

    vec_t        vecs [5];
    int          total = 0;
    int          bad   = 0;
    logic [7:0]  tx_buf [0:127];
    logic [7:0]  cap    [0:255];
    int          cap_n, er_n, er_at, done_n, und_n, gap, busy_bad;
    logic [31:0] last_fcs;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sw_crc(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic fill(input logic [7:0] seed, input logic [7:0] step, input int len);
        for (int k = 0; k < len; k++) tx_buf[k] = 8'(seed + step * k);
    endtask

    task automatic send(input int len, input bit mark_last, input bit hold);
        for (int i = 0; i < len; i++) begin
            int w;
            s_data  = tx_buf[i];
            s_valid = 1'b1;
            s_last  = mark_last && (i == len - 1);
            w = 0;
            @(negedge clk);
            while (!s_ready && w < 500) begin
                w++;
                @(negedge clk);
            end
            if (!s_ready) begin
                total++;
                bad++;
                $display("FAIL send_timeout: got s_ready=0 want 1 at byte %0d", i);
            end
            @(posedge clk);
            #1;
        end
        s_valid = hold;
        s_last  = 1'b0;
    endtask

    // Called at a negedge; counts idle cycles, then records every tx_en byte.
    task automatic capture(input int bound);
        cap_n = 0; er_n = 0; er_at = -1; done_n = 0; und_n = 0; gap = 0;
        while (!gmii_tx_en && gap < bound) begin
            gap++;
            @(negedge clk);
        end
        if (!gmii_tx_en) begin
            total++;
            bad++;
            $display("FAIL capture_timeout: got tx_en=0 want 1");
        end else begin
            if (!tx_busy) busy_bad++;
            while (gmii_tx_en && cap_n < 256) begin
                cap[cap_n] = gmii_txd;
                if (gmii_tx_er) begin
                    er_n++;
                    er_at = cap_n;
                end
                done_n += int'(frame_done);
                und_n  += int'(underrun);
                cap_n++;
                @(negedge clk);
            end
        end
    endtask

    task automatic check_frame(input string tag, input int len, input int exp_cycles);
        int pads, perr, derr;
        logic [31:0] c;
        pads = (PAD_ON && len < 60) ? 60 - len : 0;
        perr = 0;
        derr = 0;
        chk({tag, "_txen_cycles"}, cap_n, exp_cycles);
        for (int i = 0; i < 7; i++) if (cap[i] !== 8'h55) perr++;
        if (cap[7] !== 8'hD5) perr++;
        chk({tag, "_preamble_sfd_errs"}, perr, 0);
        for (int i = 0; i < len; i++) if (cap[8 + i] !== tx_buf[i]) derr++;
        for (int j = 0; j < pads; j++) if (cap[8 + len + j] !== 8'h00) derr++;
        chk({tag, "_payload_errs"}, derr, 0);
        c = 32'hFFFFFFFF;
        for (int i = 0; i < len; i++) c = sw_crc(c, tx_buf[i]);
        for (int j = 0; j < pads; j++) c = sw_crc(c, 8'h00);
        last_fcs = (cap_n >= 12) ? {cap[cap_n - 1], cap[cap_n - 2], cap[cap_n - 3], cap[cap_n - 4]} : 32'h0;
        chk({tag, "_fcs"}, last_fcs, ~c);
        chk({tag, "_frame_done_pulses"}, done_n, 1);
        chk({tag, "_tx_er_cycles"}, er_n, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{9,  8'h31, 8'h01, 21, 72, 32'hCBF43926};
        vecs[1] = '{10, 8'hA0, 8'h03, 22, 72, 32'h0};
        vecs[2] = '{1,  8'h5A, 8'h00, 13, 72, 32'h0};
        vecs[3] = '{60, 8'h00, 8'h01, 72, 72, 32'h0};
        vecs[4] = '{64, 8'hC3, 8'h05, 76, 76, 32'h0};
        busy_bad = 0;

        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_tx_en", gmii_tx_en, 0);
        chk("reset_tx_er", gmii_tx_er, 0);
        chk("reset_txd", gmii_txd, 8'h00);
        chk("reset_s_ready", s_ready, 0);
        chk("reset_tx_busy", tx_busy, 0);
        chk("reset_frame_cnt", frame_cnt, 16'h0);
        chk("reset_pulses", {frame_done, underrun}, 0);

        for (int v = 0; v < 5; v++) begin
            fill(vecs[v].seed, vecs[v].step, vecs[v].len);
            fork
                send(vecs[v].len, 1'b1, 1'b0);
                begin
                    @(negedge clk);
                    capture(300);
                end
            join
            check_frame($sformatf("vec%0d", v), vecs[v].len, PAD_ON ? vecs[v].cyc_pad : vecs[v].cyc_nopad);
            if (!PAD_ON && vecs[v].fcs_nopad != 32'h0) chk($sformatf("vec%0d_fcs_const", v), last_fcs, vecs[v].fcs_nopad);
            chk($sformatf("vec%0d_frame_cnt", v), frame_cnt, 16'(v + 1));
        end

        // Underrun after 5 of 20 bytes
        fill(8'h11, 8'h02, 20);
        fork
            send(5, 1'b0, 1'b0);
            begin
                @(negedge clk);
                capture(300);
            end
        join
        chk("underrun_txen_cycles", cap_n, 14);
        chk("underrun_er_cycles", er_n, 1);
        chk("underrun_er_pos", er_at, 13);
        chk("underrun_er_txd", cap[13], 8'h00);
        chk("underrun_pulse", und_n, 1);
        chk("underrun_no_done", done_n, 0);
        chk("underrun_frame_cnt", frame_cnt, 16'd5);

        // Back-to-back 64-byte frames with s_valid held
        fill(8'h7E, 8'h0B, 64);
        fork
            begin
                send(64, 1'b1, 1'b1);
                send(64, 1'b1, 1'b0);
            end
            begin
                @(negedge clk);
                capture(300);
                check_frame("b2b_a", 64, 76);
                capture(300);
                chk("b2b_ifg_gap", gap, 12);
                check_frame("b2b_b", 64, 76);
            end
        join
        chk("b2b_frame_cnt", frame_cnt, 16'd7);

        // Reset while the third FCS byte is on the wire
        fill(8'h40, 8'h01, 20);
        fork
            send(20, 1'b1, 1'b0);
            begin
                int w, n;
                w = 0;
                n = 0;
                @(negedge clk);
                while (!gmii_tx_en && w < 300) begin
                    w++;
                    @(negedge clk);
                end
                while (gmii_tx_en && n < 30) begin
                    n++;
                    @(negedge clk);
                end
                chk("rst_fcs3_reached", {31'h0, gmii_tx_en}, 1);
                rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
                @(negedge clk);
                chk("rst_mid_tx_en", gmii_tx_en, 0);
                chk("rst_mid_tx_er", gmii_tx_er, 0);
                chk("rst_mid_s_ready", s_ready, 0);
                chk("rst_mid_tx_busy", tx_busy, 0);
                n = 0;
                for (int k = 0; k < 20; k++) begin
                    n += int'(gmii_tx_en);
                    @(negedge clk);
                end
                chk("rst_mid_no_fcs", n, 0);
            end
        join
        fill(vecs[0].seed, vecs[0].step, vecs[0].len);
        fork
            send(vecs[0].len, 1'b1, 1'b0);
            begin
                @(negedge clk);
                capture(300);
            end
        join
        check_frame("post_rst", vecs[0].len, PAD_ON ? vecs[0].cyc_pad : vecs[0].cyc_nopad);
        chk("post_rst_frame_cnt", frame_cnt, 16'd1);

        // frame_cnt wrap
        @(negedge clk);
        force dut.frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt;
        @(negedge clk);
        chk("wrap_preload", frame_cnt, 16'hFFFF);
        fill(8'hE0, 8'h01, 16);
        fork
            send(16, 1'b1, 1'b0);
            begin
                @(negedge clk);
                capture(300);
            end
        join
        chk("wrap_frame_cnt", frame_cnt, 16'h0000);
        chk("tx_busy_during_frames", busy_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
